// File: rtl/mem_stage_pkg.sv
// Shared types and op-class helpers for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_LD_B  = 4'd1,
    OP_LD_H  = 4'd2,
    OP_LD_W  = 4'd3,
    OP_LD_BU = 4'd4,
    OP_LD_HU = 4'd5,
    OP_ST_B  = 4'd6,
    OP_ST_H  = 4'd7,
    OP_ST_W  = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LD_B) && (op <= OP_LD_HU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_ST_B) && (op <= OP_ST_W);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LD_H) || (op == OP_LD_HU) || (op == OP_ST_H);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LD_W) || (op == OP_ST_W);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane selection and sign/zero extension; purely combinational.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [3:0]        mem_op,
  output logic [DATA_W-1:0] rw_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (addr)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];

    rw_data = rdata;
    case (mem_op)
      OP_LD_B:  rw_data = {{24{byte_s[7]}}, byte_s};
      OP_LD_BU: rw_data = {24'h0, byte_s};
      OP_LD_H:  rw_data = {{16{half_s[15]}}, half_s};
      OP_LD_HU: rw_data = {16'h0, half_s};
      default:  rw_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: one instruction in flight, data-memory req/gnt/rvalid access, WB valid/ready.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int INST_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [INST_W-1:0] ex_inst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [3:0]        ex_mem_op,
  input  logic [REG_W-1:0]  ex_rw_addr,
  input  logic              ex_rw_en,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_pc,
  output logic [INST_W-1:0] mem_inst,
  output logic [DATA_W-1:0] mem_rw_data,
  output logic [REG_W-1:0]  mem_rw_addr,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_exc,
`endif
  output logic              mem_rw_en
);

  state_t            state, state_nx, accept_dest;
  logic              drain_p1, drain_nx;
  logic [ADDR_W-1:0] pc_p1, addr_p1;
  logic [INST_W-1:0] inst_p1;
  logic [DATA_W-1:0] sdata_p1, rw_data_p1, load_data;
  logic [3:0]        op_p1, ex_op;
  logic [REG_W-1:0]  rw_addr_p1;
  logic              rw_en_p1;
  logic              accept, ex_misalign;

  assign ex_ready = (state == IDLE) || ((state == DONE) && mem_ready);
  assign accept   = ex_valid && ex_ready && !flush;
  // Unused opcodes collapse to NONE so the rest of the stage sees only legal ops.
  assign ex_op    = (is_load(ex_mem_op) || is_store(ex_mem_op)) ? ex_mem_op : OP_NONE;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_p1;
  assign ex_misalign = (is_half(ex_op) && ex_result[0]) ||
                       (is_word(ex_op) && (ex_result[1:0] != 2'b00));
`else
  assign ex_misalign = 1'b0;
`endif

  assign accept_dest = ((ex_op == OP_NONE) || ex_misalign) ? DONE : REQ;

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (dmem_rdata),
    .addr    (addr_p1[1:0]),
    .mem_op  (op_p1),
    .rw_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      drain_p1 <= 1'b0;
    end else begin
      state    <= state_nx;
      drain_p1 <= drain_nx;
    end
  end

  // A granted load cannot be cancelled: flush only marks it to be drained.
  always_comb begin
    state_nx = state;
    drain_nx = drain_p1;
    case (state)
      IDLE: if (accept) state_nx = accept_dest;
      REQ: begin
        if (dmem_gnt) begin
          if (is_load(op_p1)) begin
            state_nx = WAIT;
            drain_nx = flush;
          end else begin
            state_nx = flush ? IDLE : DONE;
          end
        end else if (flush) begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (flush) drain_nx = 1'b1;
        if (dmem_rvalid) begin
          state_nx = (drain_p1 || flush) ? IDLE : DONE;
          drain_nx = 1'b0;
        end
      end
      DONE: begin
        if (flush)          state_nx = IDLE;
        else if (mem_ready) state_nx = accept ? accept_dest : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Payload capture (p1 = value held by this stage)
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_p1      <= ex_pc;
      inst_p1    <= ex_inst;
      addr_p1    <= ex_result[ADDR_W-1:0];
      sdata_p1   <= ex_store_data;
      op_p1      <= ex_op;
      rw_data_p1 <= ex_result;
      rw_addr_p1 <= ex_rw_addr;
      rw_en_p1   <= ex_rw_en && !is_store(ex_op) && !ex_misalign;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_p1 <= ex_misalign;
`endif
    end else if ((state == WAIT) && dmem_rvalid) begin
      rw_data_p1 <= load_data;
    end
  end

  always_comb begin
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wstrb  = 4'b0000;
    dmem_wdata  = '0;
    mem_valid   = 1'b0;
    mem_pc      = '0;
    mem_inst    = '0;
    mem_rw_data = '0;
    mem_rw_addr = '0;
    mem_rw_en   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_exc = 1'b0;
`endif
    case (state)
      REQ: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store(op_p1);
        dmem_addr = {addr_p1[ADDR_W-1:2], 2'b00};
        if (is_store(op_p1)) begin
          case (op_p1)
            OP_ST_B: begin
              dmem_wstrb = 4'b0001 << addr_p1[1:0];
              dmem_wdata = {4{sdata_p1[7:0]}};
            end
            OP_ST_H: begin
              dmem_wstrb = addr_p1[1] ? 4'b1100 : 4'b0011;
              dmem_wdata = {2{sdata_p1[15:0]}};
            end
            default: begin
              dmem_wstrb = 4'b1111;
              dmem_wdata = sdata_p1;
            end
          endcase
        end
      end
      DONE: begin
        mem_valid   = 1'b1;
        mem_pc      = pc_p1;
        mem_inst    = inst_p1;
        mem_rw_data = rw_data_p1;
        mem_rw_addr = rw_addr_p1;
        mem_rw_en   = rw_en_p1;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_exc = misalign_p1;
`endif
      end
      default: ;
    endcase
  end

endmodule
